argmax_sched: RTL and testbench

Streaming argmax controller between the final fully-connected layer and the fault-class output of the 1D-CNN bearing classifier. It accepts the NODES logits of one inference frame serially over a valid/ready handshake, tracks the signed running maximum and its class index, and presents one class result per frame over a second valid/ready handshake. It also flags frames whose length does not match NODES and counts completed frames.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/argmax_step.sv | 26 ++
 rtl/argmax_sched.sv | 111 +++++++++++
 tb/tb_argmax_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the 1D-CNN bearing classifier back end.
// Imported by the FC layer, the argmax scheduler and its compare/select step.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NODES      = 10;
  localparam int CLS_W      = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

endpackage

// File: rtl/argmax_step.sv
// One signed compare/select stage of a running argmax.
// The first beat seeds the maximum unconditionally; ties go to the later (higher) class.
module argmax_step
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int CLS_W      = cnn_pkg::CLS_W
) (
  input  logic [DATA_WIDTH-1:0] cur_max,
  input  logic [CLS_W-1:0]      cur_cls,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CLS_W-1:0]      idx,
  input  logic                  first,
  output logic [DATA_WIDTH-1:0] nxt_max,
  output logic [CLS_W-1:0]      nxt_cls
);

  logic take;

  always_comb begin
    take    = first || ($signed(data) >= $signed(cur_max));
    nxt_max = take ? data : cur_max;
    nxt_cls = take ? idx + CLS_W'(1) : cur_cls;
  end

endmodule

// File: rtl/argmax_sched.sv
// Streaming argmax controller: collects one frame of signed logits, then holds the
// winning class, its value and a frame-length error flag until the result is taken.
module argmax_sched
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int NODES      = cnn_pkg::NODES,
  parameter int CLS_W      = cnn_pkg::CLS_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CLS_W-1:0]      out_class,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic                  out_err,
  output logic [15:0]           frame_cnt
);

  state_t state;
  state_t state_nxt;

  logic [CLS_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] run_max;
  logic [CLS_W-1:0]      run_cls;
  logic [DATA_WIDTH-1:0] nxt_max;
  logic [CLS_W-1:0]      nxt_cls;

  logic beat;
  logic take;
  logic at_end_idx;
  logic frame_end;
  logic len_err;

  argmax_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLS_W      (CLS_W)
  ) u_step (
    .cur_max (run_max),
    .cur_cls (run_cls),
    .data    (in_data),
    .idx     (idx),
    .first   (idx == '0),
    .nxt_max (nxt_max),
    .nxt_cls (nxt_cls)
  );

  // A frame closes on whichever comes first: in_last or the NODES-th beat.
  always_comb begin
    beat       = in_valid && in_ready;
    take       = out_valid && out_ready;
    at_end_idx = (idx == CLS_W'(NODES - 1));
    frame_end  = beat && (in_last || at_end_idx);
    len_err    = in_last ^ at_end_idx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (frame_end) state_nxt = RESULT;
      RESULT:  if (take)      state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Handshake flags are registered copies of the next state so in_ready stays low in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      idx       <= '0;
      run_max   <= '0;
      run_cls   <= '0;
      out_class <= '0;
      out_max   <= '0;
      out_err   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      in_ready  <= (state_nxt == COLLECT);
      out_valid <= (state_nxt == RESULT);
      if (beat) begin
        if (frame_end) begin
          idx       <= '0;
          out_class <= nxt_cls;
          out_max   <= nxt_max;
          out_err   <= len_err;
        end else begin
          idx     <= idx + CLS_W'(1);
          run_max <= nxt_max;
          run_cls <= nxt_cls;
        end
      end
      if (take) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_argmax_sched.sv
// Directed self-checking bench for argmax_sched: expected results are queued as each
// frame is driven and popped when the DUT presents its result.
module tb_argmax_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_class;
  logic [15:0] out_max;
  logic        out_err;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [3:0]  cls;
    logic [15:0] mx;
    logic        err;
  } want_t;

  want_t want_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    want_cnt = 0;

  argmax_sched dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_max   (out_max),
    .out_err   (out_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Drives one beat and holds it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [15:0] data, input logic last);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      ok = in_ready;
      tick();
      if (ok) break;
    end
    if (!ok) checkOutput("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] beats[10], input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      applyStimulus(beats[k], k == last_at);
    end
  endtask

  // Waits for out_valid, compares against the scoreboard head, then completes the handshake.
  task automatic take_result(input string tag);
    logic  seen;
    want_t w;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      checkOutput({tag, "_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (want_q.size() == 0) begin
      checkOutput({tag, "_unexpected_result"}, 32'd1, 32'd0);
      return;
    end
    w = want_q.pop_front();
    checkOutput({tag, "_class"}, 32'(out_class), 32'(w.cls));
    checkOutput({tag, "_max"}, 32'(out_max), 32'(w.mx));
    checkOutput({tag, "_err"}, 32'(out_err), 32'(w.err));
    checkOutput({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    want_cnt  = (want_cnt + 1) & 32'hFFFF;
    checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(want_cnt));
    checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] f[10];
    int          neg[10];

    $display("[TB] start");

    // Reset state
    reset = 1'b0;
    tick(); tick(); tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_class", 32'(out_class), 32'd0);
    checkOutput("rst_out_max", 32'(out_max), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rel_out_valid", 32'(out_valid), 32'd0);

    // Ascending ramp with in_last on beat 10
    for (int k = 0; k < 10; k++) f[k] = 16'((k + 1) * 10);
    want_q.push_back('{cls: 4'd10, mx: 16'd100, err: 1'b0});
    send_frame(f, 10, 9);
    checkOutput("ramp_latency", 32'(out_valid), 32'd1);
    take_result("ramp");

    // All-negative frame
    neg = '{-5, -3, -8, -9, -7, -6, -10, -4, -12, -11};
    for (int k = 0; k < 10; k++) f[k] = 16'(neg[k]);
    want_q.push_back('{cls: 4'd2, mx: 16'hFFFD, err: 1'b0});
    send_frame(f, 10, 9);
    take_result("neg");

    // Tie goes to the higher class
    for (int k = 0; k < 10; k++) f[k] = 16'd1;
    f[2] = 16'd7;
    f[5] = 16'd7;
    want_q.push_back('{cls: 4'd6, mx: 16'd7, err: 1'b0});
    send_frame(f, 10, 9);
    take_result("tie");

    // Early in_last on beat 4
    f[0] = 16'd2; f[1] = 16'd9; f[2] = 16'd1; f[3] = 16'd3;
    want_q.push_back('{cls: 4'd2, mx: 16'd9, err: 1'b1});
    send_frame(f, 4, 3);
    take_result("short");

    // Ten beats with no in_last
    for (int k = 0; k < 10; k++) f[k] = 16'(k + 1);
    want_q.push_back('{cls: 4'd10, mx: 16'd10, err: 1'b1});
    send_frame(f, 10, -1);
    take_result("long");

    // Backpressure: result held while a new beat waits at the input
    for (int k = 0; k < 10; k++) f[k] = 16'(9 - k);
    want_q.push_back('{cls: 4'd1, mx: 16'd9, err: 1'b0});
    send_frame(f, 10, 9);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'd66;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_class", 32'(out_class), 32'd1);
      checkOutput("bp_hold_max", 32'(out_max), 32'd9);
      checkOutput("bp_hold_err", 32'(out_err), 32'd0);
    end
    take_result("bp");
    want_q.push_back('{cls: 4'd1, mx: 16'd66, err: 1'b0});
    applyStimulus(16'd66, 1'b0);
    for (int k = 1; k < 10; k++) applyStimulus(16'(k), k == 9);
    take_result("bp_next");

    // Reset after five beats discards the frame
    for (int k = 0; k < 5; k++) applyStimulus(16'(k + 1), 1'b0);
    reset = 1'b0;
    tick(); tick();
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out_class", 32'(out_class), 32'd0);
    checkOutput("mid_rst_out_max", 32'(out_max), 32'd0);
    checkOutput("mid_rst_out_err", 32'(out_err), 32'd0);
    checkOutput("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    want_cnt = 0;
    reset = 1'b1;
    tick();
    checkOutput("mid_rel_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) f[k] = 16'd0;
    f[3] = 16'd50;
    want_q.push_back('{cls: 4'd4, mx: 16'd50, err: 1'b0});
    send_frame(f, 10, 9);
    take_result("post_rst");

    checkOutput("queue_drained", 32'(want_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
